// File: rtl/bp_pkg.sv
// Shared types and helpers for the decode-stage branch history table.
package bp_pkg;

  // 2-bit saturating counter states; bit [1] is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_RESET_STATE = WNT;

  function automatic bht_state_t sat_inc(input bht_state_t s);
    return (s == ST) ? ST : bht_state_t'(s + 2'd1);
  endfunction

  function automatic bht_state_t sat_dec(input bht_state_t s);
    return (s == SNT) ? SNT : bht_state_t'(s - 2'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// W-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next value: bump only when enabled and not already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Decode-stage 2-bit BHT: combinational prediction, beq/bne resolution,
// training on resolve, and saturating resolve/mispredict statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int N        = 32,
  parameter int IDX_BITS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pred_pc,
  output logic         pred_taken,
  input  logic         resolve_valid,
  input  logic [N-1:0] resolve_pc,
  input  logic         resolve_is_bne,
  input  logic         resolve_eq,
  input  logic         resolve_pred_taken,
  output logic         actual_taken,
  output logic         mispredict,
  output logic [N-1:0] resolve_count,
  output logic [N-1:0] mispredict_count
);

  localparam int DEPTH = 2 ** IDX_BITS;

  bht_state_t          table_q [DEPTH];
  bht_state_t          entry_d;
  logic [IDX_BITS-1:0] pred_idx, res_idx;

  // Word-aligned index; upper PC bits alias by design and byte offset is ignored.
  assign pred_idx = pred_pc[IDX_BITS+1:2];
  assign res_idx  = resolve_pc[IDX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, resolve_pc};

  // Prediction reads the stored entry directly: a same-cycle update is not
  // forwarded, so a colliding read sees the pre-update value.
  assign pred_taken = table_q[pred_idx][1];

  // bne inverts the comparator result; driven whether or not a branch is valid.
  assign actual_taken = resolve_is_bne ? ~resolve_eq : resolve_eq;
  assign mispredict   = resolve_valid & (actual_taken != resolve_pred_taken);

  // Trained value for the resolving entry.
  always_comb begin
    entry_d = table_q[res_idx];
    if (actual_taken) entry_d = sat_inc(table_q[res_idx]);
    else              entry_d = sat_dec(table_q[res_idx]);
  end

  // Table storage: async reset to all-WNT, one entry written per resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= BHT_RESET_STATE;
    end else if (resolve_valid) begin
      table_q[res_idx] <= entry_d;
    end
  end

  sat_counter #(.W(N)) u_resolve_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (resolve_valid),
    .count_o (resolve_count)
  );

  sat_counter #(.W(N)) u_mispredict_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (mispredict),
    .count_o (mispredict_count)
  );

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pred_pc = '0, resolve_pc = '0;
  logic        resolve_valid = 1'b0, resolve_is_bne = 1'b0, resolve_eq = 1'b0, resolve_pred_taken = 1'b0;
  logic        pred_taken, actual_taken, mispredict;
  logic [31:0] resolve_count, mispredict_count;

  // Narrow instance for counter saturation.
  logic [3:0]  n_pred_pc = '0, n_resolve_pc = '0;
  logic        n_valid = 1'b0, n_pred = 1'b0;
  logic        n_pred_taken, n_actual, n_misp;
  logic [3:0]  n_rcnt, n_mcnt;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  branch_predictor #(.N(32), .IDX_BITS(6)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_is_bne(resolve_is_bne),
    .resolve_eq(resolve_eq), .resolve_pred_taken(resolve_pred_taken),
    .actual_taken(actual_taken), .mispredict(mispredict),
    .resolve_count(resolve_count), .mispredict_count(mispredict_count)
  );

  branch_predictor #(.N(4), .IDX_BITS(2)) dut4 (
    .clk(clk), .rst(rst), .pred_pc(n_pred_pc), .pred_taken(n_pred_taken),
    .resolve_valid(n_valid), .resolve_pc(n_resolve_pc), .resolve_is_bne(1'b0),
    .resolve_eq(1'b1), .resolve_pred_taken(n_pred),
    .actual_taken(n_actual), .mispredict(n_misp),
    .resolve_count(n_rcnt), .mispredict_count(n_mcnt)
  );

  // One resolve cycle: drive at negedge, check combinational outputs before the
  // edge, then check the trained prediction just after the edge.
  task automatic res_cycle(input string nm, input logic [31:0] pc, input logic bne, input logic eq,
                           input logic pt, input logic exp_mis, input logic exp_pred_after);
    @(negedge clk);
    resolve_valid = 1'b1; resolve_pc = pc; pred_pc = pc;
    resolve_is_bne = bne; resolve_eq = eq; resolve_pred_taken = pt;
    #1;
    tests++;
    if (mispredict !== exp_mis) begin
      fails++; $display("FAIL %s mispredict: got %0b exp %0b", nm, mispredict, exp_mis);
    end
    @(posedge clk); #1;
    tests++;
    if (pred_taken !== exp_pred_after) begin
      fails++; $display("FAIL %s pred_after: got %0b exp %0b", nm, pred_taken, exp_pred_after);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    resolve_valid = 1'b0; n_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    for (int k = 0; k < 64; k++) begin
      pred_pc = 32'(4 * k); #1;
      tests++;
      if (pred_taken !== 1'b0) begin
        fails++; $display("FAIL reset_pred pc=%0h: got %0b exp 0", pred_pc, pred_taken);
      end
    end
    tests++;
    if (resolve_count !== 32'd0 || mispredict_count !== 32'd0) begin
      fails++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", resolve_count, mispredict_count);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_training();
    // WNT -> WT -> ST -> ST; carried prediction follows the table.
    res_cycle("train1", 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    res_cycle("train2", 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    res_cycle("train3", 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tests++;
    if (resolve_count !== 32'd3 || mispredict_count !== 32'd1) begin
      fails++; $display("FAIL train_counts: got %0d/%0d exp 3/1", resolve_count, mispredict_count);
    end
  endtask

  task automatic test_bne_saturation();
    // bne with eq=1 is not taken: ST -> WT -> WNT.
    res_cycle("bne1", 32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    res_cycle("bne2", 32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) res_cycle("bne_floor", 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // From SNT one taken lands on WNT (still 0), a second on WT.
    res_cycle("from_snt1", 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    res_cycle("from_snt2", 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tests++;
    if (resolve_count !== 32'd11 || mispredict_count !== 32'd5) begin
      fails++; $display("FAIL bne_counts: got %0d/%0d exp 11/5", resolve_count, mispredict_count);
    end
    // Direction is driven without resolve_valid; no mispredict then.
    @(negedge clk);
    resolve_valid = 1'b0; resolve_is_bne = 1'b1; resolve_eq = 1'b0; resolve_pred_taken = 1'b0;
    #1;
    tests++;
    if (actual_taken !== 1'b1 || mispredict !== 1'b0) begin
      fails++; $display("FAIL idle_dir: got %0b/%0b exp 1/0", actual_taken, mispredict);
    end
  endtask

  task automatic test_collision();
    // A taken branch with resolve_valid=0 must not train entry 2.
    @(negedge clk);
    resolve_valid = 1'b0; resolve_pc = 32'h8; pred_pc = 32'h8; resolve_is_bne = 1'b0; resolve_eq = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (pred_taken !== 1'b0) begin
      fails++; $display("FAIL no_valid_update: got %0b exp 0", pred_taken);
    end
    @(negedge clk);
    resolve_valid = 1'b1; resolve_pc = 32'h0; pred_pc = 32'h100;
    resolve_is_bne = 1'b0; resolve_eq = 1'b1; resolve_pred_taken = 1'b0;
    #1;
    tests++;
    if (pred_taken !== 1'b0) begin
      fails++; $display("FAIL collide_same: got %0b exp 0", pred_taken);
    end
    @(posedge clk); #1;
    tests++;
    if (pred_taken !== 1'b1) begin
      fails++; $display("FAIL collide_next: got %0b exp 1", pred_taken);
    end
    idle_cycle();
  endtask

  task automatic test_counter_sat();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_valid = 1'b1; n_resolve_pc = 4'h4; n_pred = 1'b0;   // always taken, predicted NT
      @(posedge clk); #1;
      if (i == 15 || i == 20) begin
        tests++;
        if (n_rcnt !== 4'hF || n_mcnt !== 4'hF) begin
          fails++; $display("FAIL cnt_sat i=%0d: got %0h/%0h exp f/f", i, n_rcnt, n_mcnt);
        end
      end
    end
    idle_cycle();
  endtask

  task automatic test_async_reset();
    res_cycle("retrain1", 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    res_cycle("retrain2", 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    resolve_valid = 1'b1; resolve_pc = 32'h40; pred_pc = 32'h40;
    resolve_is_bne = 1'b0; resolve_eq = 1'b1; resolve_pred_taken = 1'b1;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (pred_taken !== 1'b0 || resolve_count !== 32'd0 || mispredict_count !== 32'd0) begin
      fails++; $display("FAIL async_rst: got %0b/%0d/%0d exp 0/0/0", pred_taken, resolve_count, mispredict_count);
    end
    @(posedge clk); #1;
    tests++;
    if (pred_taken !== 1'b0 || resolve_count !== 32'd0) begin
      fails++; $display("FAIL rst_edge: got %0b/%0d exp 0/0", pred_taken, resolve_count);
    end
    @(negedge clk); rst = 1'b0; resolve_valid = 1'b0;
    // WNT (not SNT) after reset: one taken resolve flips to WT.
    res_cycle("post_rst", 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tests++;
    if (resolve_count !== 32'd1) begin
      fails++; $display("FAIL post_rst_count: got %0d exp 1", resolve_count);
    end
  endtask

  initial begin
    test_reset();
    test_training();
    test_bne_saturation();
    test_collision();
    test_counter_sat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
